// File: rtl/cim_pkg.sv
// Shared definitions for the CIM macro controller and its op scheduler.
package cim_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RD  = 2'b01,
    OP_WR  = 2'b10,
    OP_CIM = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Host (owner 0) has no CIM capability; NOP is never a legal command.
  function automatic logic is_illegal(input op_e op, input logic owner);
    return (op == OP_NOP) || (!owner && (op == OP_CIM));
  endfunction

endpackage

// File: rtl/cim_rr_arb2.sv
// Two-way round-robin arbiter: favours the requester that was not granted last.
module cim_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant_c
);

  logic ptr_q;
  logic pref;

  assign pref = ~ptr_q;

  always_comb begin
    grant_c = 2'b00;
    if (valid[pref]) begin
      grant_c[pref] = 1'b1;
    end else if (valid[ptr_q]) begin
      grant_c[ptr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept && (|grant_c)) begin
      ptr_q <= grant_c[1];
    end
  end

endmodule

// File: rtl/cim_op_sched.sv
// Round-robin command scheduler in front of the CIM macro controller:
// grants one requester, issues the op, waits out busy and returns a response.
module cim_op_sched #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CIM_W   = 32,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             r_valid,
  output logic [1:0]             r_ready,
  input  logic [1:0][1:0]        r_op,
  input  logic [1:0][ADDR_W-1:0] r_addr,
  input  logic [1:0][DATA_W-1:0] r_wdata,
  output logic [1:0]             rsp_valid,
  output logic                   rsp_err,
  output logic [CIM_W-1:0]       rsp_data,
  output logic [1:0]             ctl_r_w_cim,
  output logic                   ctl_start,
  input  logic                   ctl_busy,
  input  logic                   ctl_rd_data_enable,
  input  logic                   ctl_cim_data_enable,
  output logic [ADDR_W-1:0]      mac_addr,
  output logic [DATA_W-1:0]      mac_wdata,
  input  logic [DATA_W-1:0]      mac_rdata,
  input  logic [CIM_W-1:0]       mac_cim_out,
  output logic                   sched_idle
);
  import cim_pkg::*;

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [CIM_W-1:0]    cap_q, cap_d;
  logic                cap_done_q, cap_done_d;

  logic                ctl_start_d;
  logic [1:0]          ctl_op_d;
  logic [ADDR_W-1:0]   mac_addr_d;
  logic [DATA_W-1:0]   mac_wdata_d;
  logic [1:0]          rsp_valid_d;
  logic                rsp_err_d;
  logic [CIM_W-1:0]    rsp_data_d;

  logic                accept_c;
  logic [1:0]          grant_c;
  logic                gnt_idx_c;
  logic                done_c;
  logic                drive_c;

  assign accept_c   = (state_q == IDLE) && (|r_valid) && !ctl_busy;
  assign gnt_idx_c  = grant_c[1];
  assign r_ready    = accept_c ? grant_c : 2'b00;
  assign sched_idle = (state_q == IDLE) && (r_valid == 2'b00);

  cim_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (r_valid),
    .accept  (accept_c),
    .grant_c (grant_c)
  );

  // Next-state, command latch, capture and registered-output computation.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    wd_d       = wd_q;
    cap_d      = cap_q;
    cap_done_d = cap_done_q;
    rsp_data_d = rsp_data;
    done_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          owner_d = gnt_idx_c;
          op_d    = op_e'(r_op[gnt_idx_c]);
          addr_d  = r_addr[gnt_idx_c];
          wdata_d = r_wdata[gnt_idx_c];
          err_d   = is_illegal(op_e'(r_op[gnt_idx_c]), gnt_idx_c);
          state_d = err_d ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        wd_d       = '0;
        cap_d      = '0;
        cap_done_d = 1'b0;
        state_d    = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if ((op_q == OP_RD) && ctl_rd_data_enable) begin
          cap_d      = CIM_W'(mac_rdata);
          cap_done_d = 1'b1;
        end
        // Only the first CIM result of an op is kept.
        if ((op_q == OP_CIM) && ctl_cim_data_enable && !cap_done_q) begin
          cap_d      = mac_cim_out;
          cap_done_d = 1'b1;
        end
        done_c = (op_q == OP_WR) || cap_done_d;
        if (!ctl_busy && done_c) begin
          state_d    = RESP;
          err_d      = 1'b0;
          rsp_data_d = cap_d;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    drive_c     = (state_d == ISSUE) || (state_d == WAIT);
    ctl_start_d = (state_d == ISSUE);
    ctl_op_d    = drive_c ? op_d : OP_NOP;
    mac_addr_d  = drive_c ? addr_d : '0;
    mac_wdata_d = drive_c ? wdata_d : '0;
    rsp_valid_d = (state_d == RESP) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    rsp_err_d   = (state_d == RESP) && err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      wd_q        <= '0;
      cap_q       <= '0;
      cap_done_q  <= 1'b0;
      ctl_start   <= 1'b0;
      ctl_r_w_cim <= 2'b00;
      mac_addr    <= '0;
      mac_wdata   <= '0;
      rsp_valid   <= 2'b00;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
      cap_q       <= cap_d;
      cap_done_q  <= cap_done_d;
      ctl_start   <= ctl_start_d;
      ctl_r_w_cim <= ctl_op_d;
      mac_addr    <= mac_addr_d;
      mac_wdata   <= mac_wdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_err     <= rsp_err_d;
      rsp_data    <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_cim_op_sched.sv
// Bench for cim_op_sched: per-requester command queues, a behavioural
// controller/macro model, and a transaction-level expectation model.
module tb_cim_op_sched;
  import cim_pkg::*;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CIM_W   = 32;
  localparam int unsigned TIMEOUT = 31;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             r_valid;
  logic [1:0]             r_ready;
  logic [1:0][1:0]        r_op;
  logic [1:0][ADDR_W-1:0] r_addr;
  logic [1:0][DATA_W-1:0] r_wdata;
  logic [1:0]             rsp_valid;
  logic                   rsp_err;
  logic [CIM_W-1:0]       rsp_data;
  logic [1:0]             ctl_r_w_cim;
  logic                   ctl_start;
  logic                   ctl_busy;
  logic                   ctl_rd_data_enable;
  logic                   ctl_cim_data_enable;
  logic [ADDR_W-1:0]      mac_addr;
  logic [DATA_W-1:0]      mac_wdata;
  logic [DATA_W-1:0]      mac_rdata;
  logic [CIM_W-1:0]       mac_cim_out;
  logic                   sched_idle;

  always #5 clk = ~clk;

  cim_op_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CIM_W(CIM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .r_valid(r_valid), .r_ready(r_ready), .r_op(r_op),
    .r_addr(r_addr), .r_wdata(r_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .ctl_r_w_cim(ctl_r_w_cim), .ctl_start(ctl_start),
    .ctl_busy(ctl_busy), .ctl_rd_data_enable(ctl_rd_data_enable),
    .ctl_cim_data_enable(ctl_cim_data_enable), .mac_addr(mac_addr),
    .mac_wdata(mac_wdata), .mac_rdata(mac_rdata), .mac_cim_out(mac_cim_out),
    .sched_idle(sched_idle)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [15:0] wdata;
    int          lat;     // cycles busy stays high after start
    int          en_at;   // cycle of the data-enable pulse (<= lat)
    logic [15:0] rdata;
    logic [31:0] cim;
    bit          hang;    // controller never finishes
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Controller + macro model, configured per transaction at grant time.
  logic [1:0]  cm_op;
  int          cm_cnt;
  int          cm_lat   = 1;
  int          cm_en_at = 1;
  logic [15:0] cm_rdata = '0;
  logic [31:0] cm_cim   = '0;
  bit          cm_hang  = 1'b0;

  always @(posedge clk) begin
    ctl_rd_data_enable  <= 1'b0;
    ctl_cim_data_enable <= 1'b0;
    if (rst) begin
      ctl_busy    <= 1'b0;
      cm_cnt      <= 0;
      cm_op       <= 2'b00;
      mac_rdata   <= '0;
      mac_cim_out <= '0;
    end else if (ctl_start) begin
      ctl_busy <= 1'b1;
      cm_cnt   <= 0;
      cm_op    <= ctl_r_w_cim;
    end else if (ctl_busy) begin
      cm_cnt <= cm_cnt + 1;
      if (cm_hang) begin
        if (|rsp_valid) ctl_busy <= 1'b0;
      end else begin
        if (cm_cnt + 1 == cm_en_at) begin
          if (cm_op == OP_RD)  begin ctl_rd_data_enable  <= 1'b1; mac_rdata   <= cm_rdata; end
          if (cm_op == OP_CIM) begin ctl_cim_data_enable <= 1'b1; mac_cim_out <= cm_cim;   end
        end
        // A second, bogus CIM result that must be ignored.
        if ((cm_op == OP_CIM) && (cm_en_at < cm_lat) && (cm_cnt + 1 == cm_en_at + 1)) begin
          ctl_cim_data_enable <= 1'b1;
          mac_cim_out         <= ~cm_cim;
        end
        if (cm_cnt + 1 == cm_lat) ctl_busy <= 1'b0;
      end
    end
  end

  // Transaction-level expectation state.
  bit          rr = 1'b0;
  bit          outst = 1'b0;
  bit          gaps = 1'b0;
  int          cyc = 0;
  int          g_cyc = 0;
  int          rsp_cyc = -1;
  bit          t_owner, t_illegal, t_hang;
  logic [1:0]  t_op;
  logic [5:0]  t_addr;
  logic [15:0] t_wdata;
  logic [31:0] t_data;
  logic [31:0] last_data = '0;

  function automatic cmd_t mk(input logic [1:0] op, input logic [5:0] addr, input logic [15:0] wd,
                              input int lat, input int en_at, input logic [15:0] rd,
                              input logic [31:0] cim, input bit hang);
    cmd_t c;
    c.op = op; c.addr = addr; c.wdata = wd; c.lat = lat; c.en_at = en_at;
    c.rdata = rd; c.cim = cim; c.hang = hang;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    int lat;
    lat = $urandom_range(1, 12);
    return mk(2'($urandom), 6'($urandom), 16'($urandom), lat, $urandom_range(1, lat),
              16'($urandom), $urandom, ($urandom_range(0, 15) == 0));
  endfunction

  // One clock: drive requesters, then check every observable output.
  task automatic step();
    cmd_t       h;
    logic [1:0] v;
    logic [1:0] exp_rdy;
    logic [1:0] exp_rv;
    bit         have;
    bit         exp_start;
    int         g;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (have) h = (i == 0) ? q0[0] : q1[0];
      v[i] = have && (!gaps || ($urandom_range(0, 3) != 0));
      if (v[i]) begin
        r_op[i] = h.op; r_addr[i] = h.addr; r_wdata[i] = h.wdata;
      end else begin
        r_op[i] = 2'($urandom); r_addr[i] = 6'($urandom); r_wdata[i] = 16'($urandom);
      end
    end
    r_valid = v;
    @(negedge clk);
    cyc++;

    g = 0;
    exp_rdy = 2'b00;
    if (!outst && !ctl_busy && (v != 2'b00)) begin
      if (v == 2'b11) g = rr ? 0 : 1;
      else            g = v[1] ? 1 : 0;
      exp_rdy[g] = 1'b1;
    end
    check_eq("r_ready", r_ready, exp_rdy);
    check_eq("sched_idle", sched_idle, !outst && (v == 2'b00));

    exp_start = outst && !t_illegal && (cyc == g_cyc + 1);
    check_eq("ctl_start", ctl_start, exp_start);
    if (outst && !t_illegal && (cyc > g_cyc) && ((rsp_cyc < 0) || (cyc < rsp_cyc))) begin
      check_eq("ctl_op", ctl_r_w_cim, t_op);
      check_eq("mac_addr", mac_addr, t_addr);
      check_eq("mac_wdata", mac_wdata, t_wdata);
    end

    if (outst && !t_illegal && !t_hang && (rsp_cyc < 0) && (cyc > g_cyc + 1) && !ctl_busy)
      rsp_cyc = cyc + 1;
    exp_rv = (outst && (cyc == rsp_cyc)) ? (t_owner ? 2'b10 : 2'b01) : 2'b00;
    check_eq("rsp_valid", rsp_valid, exp_rv);
    check_eq("rsp_data", rsp_data, (exp_rv != 2'b00) ? t_data : last_data);
    if (exp_rv != 2'b00) begin
      check_eq("rsp_err", rsp_err, t_illegal || t_hang);
      last_data = t_data;
      outst = 1'b0;
    end

    if (exp_rdy != 2'b00) begin
      h = (g == 1) ? q1.pop_front() : q0.pop_front();
      outst     = 1'b1;
      rr        = (g == 1);
      g_cyc     = cyc;
      t_owner   = (g == 1);
      t_op      = h.op;
      t_addr    = h.addr;
      t_wdata   = h.wdata;
      t_illegal = (h.op == 2'b00) || ((g == 0) && (h.op == 2'b11));
      t_hang    = !t_illegal && h.hang;
      rsp_cyc   = t_illegal ? cyc + 1 : (t_hang ? cyc + 2 + int'(TIMEOUT) : -1);
      if (t_illegal || t_hang) t_data = last_data;
      else if (h.op == 2'b01)  t_data = {16'h0000, h.rdata};
      else if (h.op == 2'b11)  t_data = h.cim;
      else                     t_data = 32'h0;
      cm_lat = h.lat; cm_en_at = h.en_at; cm_rdata = h.rdata; cm_cim = h.cim; cm_hang = t_hang;
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (((q0.size() + q1.size()) != 0 || outst) && (n < budget)) begin
      step();
      n++;
    end
    check_eq("drain_budget", (n >= budget), 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 2'b00);
    check_eq({tag, "_rsp_err"}, rsp_err, 1'b0);
    check_eq({tag, "_rsp_data"}, rsp_data, 32'h0);
    check_eq({tag, "_start"}, ctl_start, 1'b0);
    check_eq({tag, "_ctl_op"}, ctl_r_w_cim, 2'b00);
    check_eq({tag, "_mac_addr"}, mac_addr, 6'h0);
    check_eq({tag, "_mac_wdata"}, mac_wdata, 16'h0);
    check_eq({tag, "_r_ready"}, r_ready, 2'b00);
    check_eq({tag, "_sched_idle"}, sched_idle, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; r_valid = 2'b00; r_op = '0; r_addr = '0; r_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("post_reset");

    // Directed: host read, engine CIM, alternating writes, timeout, illegal ops.
    q0.push_back(mk(2'b01, 6'd5, 16'h0, 3, 3, 16'hA5A5, 32'h0, 1'b0));
    run(100);
    q1.push_back(mk(2'b11, 6'd9, 16'h0, 10, 10, 16'h0, 32'h12345678, 1'b0));
    run(100);
    for (int k = 0; k < 2; k++) begin
      q0.push_back(mk(2'b10, 6'(k + 1), 16'(16'h1000 + k), 2, 1, 16'h0, 32'h0, 1'b0));
      q1.push_back(mk(2'b10, 6'(k + 33), 16'(16'h2000 + k), 2, 1, 16'h0, 32'h0, 1'b0));
    end
    run(200);
    q0.push_back(mk(2'b01, 6'd7, 16'h0, 5, 5, 16'hBEEF, 32'h0, 1'b1));
    q0.push_back(mk(2'b10, 6'd8, 16'h5555, 2, 1, 16'h0, 32'h0, 1'b0));
    run(200);
    q0.push_back(mk(2'b00, 6'd1, 16'h0, 1, 1, 16'h0, 32'h0, 1'b0));
    q0.push_back(mk(2'b11, 6'd2, 16'h0, 1, 1, 16'h0, 32'h0, 1'b0));
    run(100);

    // Randomized traffic with valid gaps on both requesters.
    gaps = 1'b1;
    for (int k = 0; k < 150; k++) begin
      q0.push_back(rnd_cmd());
      q1.push_back(rnd_cmd());
    end
    run(20000);

    // Reset in the middle of an engine CIM wait.
    gaps = 1'b0;
    q1.push_back(mk(2'b11, 6'd3, 16'h0, 20, 15, 16'h0, 32'hCAFEF00D, 1'b0));
    for (int k = 0; k < 40 && !(outst && (cyc >= g_cyc + 5)); k++) step();
    check_eq("rst_setup_in_wait", (outst && (cyc >= g_cyc + 5)), 1'b1);
    check_eq("rst_setup_busy", ctl_busy, 1'b1);
    @(posedge clk); #1 rst = 1'b1; r_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check_quiet("mid_reset");
    @(posedge clk); #1 rst = 1'b0;
    outst = 1'b0; rr = 1'b0; last_data = '0; rsp_cyc = -1;
    @(negedge clk);
    check_quiet("after_mid_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("no_late_rsp", rsp_valid, 2'b00);
    end

    // Traffic again after the abort.
    gaps = 1'b1;
    for (int k = 0; k < 20; k++) begin
      q0.push_back(rnd_cmd());
      q1.push_back(rnd_cmd());
    end
    run(5000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cim_op_sched.md
Name: cim_op_sched

Overview:
- Two-requester scheduler in front of the CIM macro controller.
- Requester 0 is the host (read/write); requester 1 is the compute engine (read/write/CIM).
- Arbitrates round-robin, latches the granted command, drives the controller's op/start/address/write-data, and waits out busy.
- Captures read data or CIM result and returns a response to the owning requester; a watchdog flags a controller that never completes.

Parameters:
ADDR_W, 6, macro row address width
DATA_W, 16, read/write data width
CIM_W, 32, CIM result width
TIMEOUT, 31, max cycles in WAIT before error (>= input bit width + 4)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
r_valid  in  2  per-requester command valid (bit i = requester i)
r_ready  out  2  per-requester accept; at most one bit high per cycle
r_op  in  2x2  per-requester op: 01 read, 10 write, 11 CIM, 00 illegal
r_addr  in  2xADDR_W  per-requester row address
r_wdata  in  2xDATA_W  per-requester write data
rsp_valid  out  2  one-cycle response pulse to requester i
rsp_err  out  1  qualifies rsp_valid: illegal op or timeout
rsp_data  out  CIM_W  read data (zero-extended) or CIM result; holds until next response
ctl_r_w_cim  out  2  op to controller
ctl_start  out  1  start strobe to controller
ctl_busy  in  1  controller busy
ctl_rd_data_enable  in  1  controller read-data valid
ctl_cim_data_enable  in  1  controller CIM-result valid
mac_addr  out  ADDR_W  row address to macro
mac_wdata  out  DATA_W  write data to macro
mac_rdata  in  DATA_W  macro read data
mac_cim_out  in  CIM_W  macro CIM result
sched_idle  out  1  high in IDLE with no pending command

Behaviour:
- Reset: state IDLE, rr pointer = 0, all outputs 0, except sched_idle = 1. Reset mid-operation aborts with no response; ctl_start stays 0.
- IDLE: if any r_valid and ctl_busy == 0:
  - grant the requester nearest after the last granted (rr); r_ready[g] = 1 that cycle (combinational);
  - latch op/addr/wdata/owner; rr <= g; go to ISSUE.
- Illegal op 00 is still accepted; go to RESP with rsp_err = 1; the controller is never started.
- Requester 0 op 11 is treated as illegal.
- ISSUE (1 cycle): ctl_start = 1; ctl_r_w_cim = latched op; mac_addr/mac_wdata driven from the latch from ISSUE through WAIT; watchdog cleared; go to WAIT.
- WAIT:
  - ctl_r_w_cim held; ctl_start = 0; watchdog increments.
  - Capture mac_rdata when ctl_rd_data_enable is high.
  - Capture mac_cim_out on the first clk posedge where ctl_cim_data_enable is high.
  - Exit to RESP when ctl_busy == 0, at least one cycle after ISSUE and the required capture is done. Required capture: read needs rdata, CIM needs result, write needs none.
  - If the watchdog reaches TIMEOUT: go to RESP with rsp_err = 1 and rsp_data unchanged.
- RESP (1 cycle): rsp_valid[owner] = 1, rsp_err as set, rsp_data = captured value; go to IDLE.
- Throughput: no accept in ISSUE/WAIT/RESP; minimum back-to-back issue spacing is ISSUE + WAIT + RESP + IDLE.
- Simultaneous valids: rr alternates; after grant to 0 a dual request goes to 1.
- r_valid dropped before grant: no action. Inputs are sampled only at grant.
- sched_idle = (state == IDLE) && r_valid == 0.

Decomposition:
- Shared package cim_pkg:
  - op encodings OP_NOP / OP_RD / OP_WR / OP_CIM (2'b00..11), common with the controller;
  - state enum IDLE / ISSUE / WAIT / RESP.
- One sub-module: cim_rr_arb2 (2-way round-robin arbiter: valid in, one-hot grant, pointer update on accept).

Test Plan:
- Host read addr 5, macro returns 16'hA5A5 on rd_data_enable → one ctl_start pulse with op 01, mac_addr 5; rsp_valid = 2'b01, rsp_data = 32'h0000A5A5, rsp_err = 0.
- Engine CIM op with busy held 10 cycles then cim_data_enable and mac_cim_out = 32'h12345678 → rsp_valid = 2'b10 after busy falls, data 32'h12345678.
- Both valid every cycle with writes → grants alternate 0,1,0,1; each r_ready single-cycle; four responses in order.
- Controller model never deasserts busy, TIMEOUT = 31 → rsp_err = 1 at cycle 31 of WAIT, then IDLE accepts the next request.
- Host op 00, then host op 11 → two error responses, ctl_start never asserted.
- rst asserted during WAIT of a CIM op → all outputs 0, no rsp_valid, sched_idle = 1 the cycle after rst deasserts with no valids.
